ro_puf_challenge_sequencer: RTL and testbench
=============================================

# ro_puf_challenge_sequencer

Drives the two-RO frequency-comparator counter block from the initiating side. It latches a challenge word and steps through RESP_BITS RO pairs, one pair per response bit. For each pair it selects the two oscillators, clears and releases the comparator counters, times a fixed measurement window, then samples the comparator's response bit. It sits between the PUF top-level/host and the RO comparator, and delivers a packed response word with a one-cycle done pulse.

## Interface
- RESP_BITS, 8: response bits per challenge; challenge width is 8*RESP_BITS.
- WINDOW, 255: measurement window length in clk cycles; legal range 1..2^WIN_BITS-1.
- WIN_BITS, 8: width of the window counter.
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request evaluation; sampled only in IDLE.
- challenge  in  8*RESP_BITS  pair list; byte i holds pair i, with sel0=[8i+7:8i+4] and sel1=[8i+3:8i].
- resp_in  in  1  comparator response bit; asynchronous to clk.
- sel0  out  4  RO select for counter 1.
- sel1  out  4  RO select for counter 2.
- cnt_rst_n  out  1  active-low clear to the comparator counters.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse; response_word and collision_mask are valid from this cycle.
- response_word  out  RESP_BITS  bit i is the result of pair i.
- collision_mask  out  RESP_BITS  bit i set when pair i has sel0==sel1.

## Operation
- resp_in passes through a 2-flop synchronizer, which runs continuously.
- FSM states: IDLE, ARM, RUN, SAMPLE, DONE.
- IDLE
  - cnt_rst_n=0 and busy=0.
  - On start=1: latch challenge, clear response_word and collision_mask, set bit index=0, go to ARM.
- ARM (2 cycles)
  - sel0/sel1 driven from byte[index]; cnt_rst_n=0.
  - Then go to RUN with the window counter at 0.
- RUN (WINDOW cycles)
  - cnt_rst_n=1; the window counter increments each cycle.
  - When the counter reaches WINDOW-1, go to SAMPLE.
- SAMPLE (1 cycle)
  - cnt_rst_n=0.
  - Capture the synchronized resp_in into response_word[index].
  - If sel0==sel1: force that bit to 0 and set collision_mask[index]. The full window still runs.
  - If index==RESP_BITS-1, go to DONE; otherwise increment index and go to ARM.
- DONE (1 cycle)
  - done=1, busy=0; then go to IDLE.
- busy=1 in ARM, RUN and SAMPLE.
- sel0/sel1 are held constant from ARM through SAMPLE of each pair.
- Reset values: state IDLE, sel0=0, sel1=0, cnt_rst_n=0, busy=0, done=0, response_word=0, collision_mask=0, index=0, window counter=0, synchronizer flops=0.
- response_word and collision_mask hold their values after DONE until the next accepted start clears them.

## Timing
- start sampled high in IDLE at edge k: ARM, busy=1 and sel for pair 0 are all visible after edge k.
- Per-pair cost is WINDOW+3 cycles: ARM 2, RUN WINDOW, SAMPLE 1.
- done is asserted exactly RESP_BITS*(WINDOW+3) cycles after edge k, for 1 cycle.
- start while busy or in DONE is ignored; it is not queued.
- start must be re-asserted in IDLE to begin a new evaluation.
- reset=1 in any state returns the block to IDLE with reset values at the next edge; a partial response is discarded.
- Response latency: the sampled bit reflects comparator state at least 2 cycles before SAMPLE, because of the synchronizer.
- WINDOW=1 is legal: 1 RUN cycle per pair.

## Configuration
- PUF_MAJORITY_VOTE_EN
  - Defined: each pair runs ARM/RUN/SAMPLE three times back-to-back with the same selects. The stored bit is the majority of the three samples. Per-pair cost becomes 3*(WINDOW+3) and done latency scales by the same factor. Collision forcing is unchanged.
  - Undefined: single evaluation per pair, as described above.

## Test plan
- Reset: assert reset for 2 cycles mid-RUN -> next cycle busy=0, cnt_rst_n=0, sel0=sel1=0, response_word=0, done never pulses.
- Basic run: RESP_BITS=8, WINDOW=4, challenge=0x0123456789ABCDEF, resp_in model = (sel0>sel1) -> done exactly 56 cycles after start; response_word bits follow the rule per byte; collision_mask=0.
- Collision: byte0=0x33, resp_in tied 1 -> response_word[0]=0 and collision_mask[0]=1; other bits are 1.
- Start while busy: pulse start at cycles 5 and 20 of a run -> single done at the nominal cycle; no restart; outputs unchanged by the extra pulses.
- Window boundary: WINDOW=1 -> cnt_rst_n high for exactly 1 cycle per pair; done at RESP_BITS*4 cycles.
- Majority (PUF_MAJORITY_VOTE_EN defined): resp_in sequence 1,0,1 across the three samples of pair 0 -> bit0=1; sequence 0,0,1 -> bit0=0; done at 3*RESP_BITS*(WINDOW+3).

Source files
------------

// File: rtl/ro_puf_challenge_sequencer_if.sv
// Host/comparator-side signal bundle for ro_puf_challenge_sequencer.
interface ro_puf_challenge_sequencer_if #(
    parameter int RESP_BITS = 8
);
    logic                   start;
    logic [8*RESP_BITS-1:0] challenge;
    logic                   resp_in;
    logic [3:0]             sel0;
    logic [3:0]             sel1;
    logic                   cnt_rst_n;
    logic                   busy;
    logic                   done;
    logic [RESP_BITS-1:0]   response_word;
    logic [RESP_BITS-1:0]   collision_mask;

    modport master (
        output start, challenge, resp_in,
        input  sel0, sel1, cnt_rst_n, busy, done, response_word, collision_mask
    );

    modport slave (
        input  start, challenge, resp_in,
        output sel0, sel1, cnt_rst_n, busy, done, response_word, collision_mask
    );
endinterface

// File: rtl/ro_puf_challenge_sequencer.sv
// Steps a challenge through RO pairs, times each comparator window and packs the response bits.
// Optional feature macro: PUF_MAJORITY_VOTE_EN (three measurements per pair, majority stored).
module ro_puf_challenge_sequencer #(
    parameter int RESP_BITS = 8,
    parameter int WINDOW    = 255,
    parameter int WIN_BITS  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    ro_puf_challenge_sequencer_if.slave bus
);
    localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [WIN_BITS-1:0] WIN_LAST = WIN_BITS'(WINDOW - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_RUN    = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   arm_cnt_r;
    logic [WIN_BITS-1:0]    win_cnt_r;
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       idx_next_s;
    logic [8*RESP_BITS-1:0] chal_r;
    logic [1:0]             sync_r;
    logic [3:0]             sel0_r;
    logic [3:0]             sel1_r;
    logic                   cnt_rst_n_r;
    logic                   busy_r;
    logic                   done_r;
    logic [RESP_BITS-1:0]   resp_r;
    logic [RESP_BITS-1:0]   coll_r;
    logic                   last_pass_s;
    logic                   vote_s;
    logic                   coll_s;
    logic                   bit_s;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0] pass_r;
    logic [1:0] votes_r;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    // Pass bookkeeping and the bit value that SAMPLE would commit this cycle
    always_comb begin
        idx_next_s = idx_r + IDX_W'(1);
        coll_s     = (sel0_r == sel1_r);
`ifdef PUF_MAJORITY_VOTE_EN
        last_pass_s = (pass_r == 2'd2);
        vote_s      = maj3(votes_r[0], votes_r[1], sync_r[1]);
`else
        last_pass_s = 1'b1;
        vote_s      = sync_r[1];
`endif
        if (coll_s) begin
            bit_s = 1'b0;
        end else begin
            bit_s = vote_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_ARM;
                else           state_s = ST_IDLE;
            end
            ST_ARM: begin
                if (arm_cnt_r) state_s = ST_RUN;
                else           state_s = ST_ARM;
            end
            ST_RUN: begin
                if (win_cnt_r == WIN_LAST) state_s = ST_SAMPLE;
                else                       state_s = ST_RUN;
            end
            ST_SAMPLE: begin
                if (last_pass_s && (idx_r == IDX_LAST)) state_s = ST_DONE;
                else                                    state_s = ST_ARM;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Two-flop synchronizer for the asynchronous comparator bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], bus.resp_in};
        end
    end

    // Datapath: challenge latch, counters, selects and response packing
    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt_r <= 1'b0;
            win_cnt_r <= '0;
            idx_r     <= '0;
            chal_r    <= '0;
            sel0_r    <= 4'd0;
            sel1_r    <= 4'd0;
            resp_r    <= '0;
            coll_r    <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
            pass_r    <= 2'd0;
            votes_r   <= 2'b00;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        chal_r    <= bus.challenge;
                        sel0_r    <= bus.challenge[7:4];
                        sel1_r    <= bus.challenge[3:0];
                        resp_r    <= '0;
                        coll_r    <= '0;
                        idx_r     <= '0;
                        arm_cnt_r <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
                        pass_r    <= 2'd0;
`endif
                    end
                end
                ST_ARM: begin
                    arm_cnt_r <= ~arm_cnt_r;
                    win_cnt_r <= '0;
                end
                ST_RUN: begin
                    win_cnt_r <= win_cnt_r + WIN_BITS'(1);
                end
                ST_SAMPLE: begin
                    if (last_pass_s) begin
                        resp_r[idx_r] <= bit_s;
                        coll_r[idx_r] <= coll_s;
`ifdef PUF_MAJORITY_VOTE_EN
                        pass_r        <= 2'd0;
`endif
                        // Selects stay put after the final pair so the comparator sees no glitch
                        if (idx_r != IDX_LAST) begin
                            idx_r  <= idx_next_s;
                            sel0_r <= chal_r[8*idx_next_s+4 +: 4];
                            sel1_r <= chal_r[8*idx_next_s +: 4];
                        end
                    end else begin
`ifdef PUF_MAJORITY_VOTE_EN
                        votes_r[pass_r[0]] <= sync_r[1];
                        pass_r             <= pass_r + 2'd1;
`endif
                    end
                end
                ST_DONE: begin
                    arm_cnt_r <= 1'b0;
                end
                default: begin
                    arm_cnt_r <= 1'b0;
                end
            endcase
        end
    end

    // Registered status outputs, decoded from the upcoming state
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_rst_n_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cnt_rst_n_r <= (state_s == ST_RUN);
            busy_r      <= (state_s == ST_ARM) || (state_s == ST_RUN) || (state_s == ST_SAMPLE);
            done_r      <= (state_s == ST_DONE);
        end
    end

    assign bus.sel0           = sel0_r;
    assign bus.sel1           = sel1_r;
    assign bus.cnt_rst_n      = cnt_rst_n_r;
    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.response_word  = resp_r;
    assign bus.collision_mask = coll_r;
endmodule

// File: tb/tb_ro_puf_challenge_sequencer.sv
// Scoreboard bench: one sequencer with WINDOW=4 and one with WINDOW=1, checked at each done pulse.
module tb_ro_puf_challenge_sequencer;
    localparam int N = 8;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int REP = 3;
`else
    localparam int REP = 1;
`endif
    localparam int LAT_A = REP * N * (4 + 3);
    localparam int LAT_B = REP * N * (1 + 3);

    localparam logic [63:0] CH_ZERO  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] CH_ONES  = 64'h1032_5476_98BA_DCFE;
    localparam logic [63:0] CH_MIXED = 64'hA089_980F_F055_1221;
    localparam logic [63:0] CH_COLL  = 64'h0123_4567_89AB_CD33;

    typedef struct {
        logic [7:0]  resp;
        logic [7:0]  mask;
        int unsigned at;
        int unsigned hi;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [1:0]  mode_a;
    logic [1:0]  mode_b;
    logic        script_a;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned hi_a = 0;
    int unsigned hi_b = 0;
    logic        done_prev_a = 1'b0;
    logic        done_prev_b = 1'b0;

    ro_puf_challenge_sequencer_if #(.RESP_BITS(N)) ifa ();
    ro_puf_challenge_sequencer_if #(.RESP_BITS(N)) ifb ();

    ro_puf_challenge_sequencer #(.RESP_BITS(N), .WINDOW(4), .WIN_BITS(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    ro_puf_challenge_sequencer #(.RESP_BITS(N), .WINDOW(1), .WIN_BITS(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator models: sel0 faster than sel1, tied high, or scripted
    always @* begin
        case (mode_a)
            2'd0:    ifa.resp_in = (ifa.sel0 > ifa.sel1);
            2'd1:    ifa.resp_in = 1'b1;
            default: ifa.resp_in = script_a;
        endcase
        case (mode_b)
            2'd0:    ifb.resp_in = (ifb.sel0 > ifb.sel1);
            default: ifb.resp_in = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor for the WINDOW=4 instance
    always @(negedge clk) begin
        if (reset) begin
            hi_a = 0;
        end else begin
            if (ifa.cnt_rst_n) hi_a++;
            if (ifa.done) begin
                check("a_done_width", 32'(done_prev_a), 32'd0);
                if (qa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_unexpected_done actual=done at cycle %0d required=no done", cyc);
                end else begin
                    exp_t e;
                    e = qa.pop_front();
                    check("a_response_word", 32'(ifa.response_word), 32'(e.resp));
                    check("a_collision_mask", 32'(ifa.collision_mask), 32'(e.mask));
                    check("a_done_cycle", cyc, e.at);
                    check("a_cnt_rst_n_high_cycles", hi_a, e.hi);
                    check("a_busy_at_done", 32'(ifa.busy), 32'd0);
                end
                hi_a = 0;
            end
        end
        done_prev_a = ifa.done;
    end

    // Monitor for the WINDOW=1 instance
    always @(negedge clk) begin
        if (reset) begin
            hi_b = 0;
        end else begin
            if (ifb.cnt_rst_n) hi_b++;
            if (ifb.done) begin
                check("b_done_width", 32'(done_prev_b), 32'd0);
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected_done actual=done at cycle %0d required=no done", cyc);
                end else begin
                    exp_t e;
                    e = qb.pop_front();
                    check("b_response_word", 32'(ifb.response_word), 32'(e.resp));
                    check("b_collision_mask", 32'(ifb.collision_mask), 32'(e.mask));
                    check("b_done_cycle", cyc, e.at);
                    check("b_cnt_rst_n_high_cycles", hi_b, e.hi);
                end
                hi_b = 0;
            end
        end
        done_prev_b = ifb.done;
    end

    // Issue a start on the WINDOW=4 instance; returns at the negedge after the accepting edge
    task automatic run_a(input logic [63:0] ch, input bit push, input logic [7:0] er, input logic [7:0] em);
        exp_t e;
        ifa.challenge = ch;
        ifa.start     = 1'b1;
        e.resp = er;
        e.mask = em;
        e.at   = cyc + 1 + LAT_A;
        e.hi   = N * 4 * REP;
        if (push) qa.push_back(e);
        @(negedge clk);
        ifa.start = 1'b0;
    endtask

    task automatic run_b(input logic [63:0] ch, input logic [7:0] er, input logic [7:0] em);
        exp_t e;
        ifb.challenge = ch;
        ifb.start     = 1'b1;
        e.resp = er;
        e.mask = em;
        e.at   = cyc + 1 + LAT_B;
        e.hi   = N * 1 * REP;
        qb.push_back(e);
        @(negedge clk);
        ifb.start = 1'b0;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_busy"}, 32'(ifa.busy), 32'd0);
        check({tag, "_done"}, 32'(ifa.done), 32'd0);
        check({tag, "_cnt_rst_n"}, 32'(ifa.cnt_rst_n), 32'd0);
        check({tag, "_sel0"}, 32'(ifa.sel0), 32'd0);
        check({tag, "_sel1"}, 32'(ifa.sel1), 32'd0);
        check({tag, "_response_word"}, 32'(ifa.response_word), 32'd0);
        check({tag, "_collision_mask"}, 32'(ifa.collision_mask), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        mode_a        = 2'd0;
        mode_b        = 2'd0;
        script_a      = 1'b0;
        ifa.start     = 1'b0;
        ifa.challenge = '0;
        ifb.start     = 1'b0;
        ifb.challenge = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_a("reset");

        // Start makes busy and pair-0 selects visible right after the accepting edge
        run_a(CH_MIXED, 1'b1, 8'hA9, 8'h04);
        check("start_busy", 32'(ifa.busy), 32'd1);
        check("start_sel0", 32'(ifa.sel0), 32'h2);
        check("start_sel1", 32'(ifa.sel1), 32'h1);
        check("start_cnt_rst_n", 32'(ifa.cnt_rst_n), 32'd0);
        repeat (LAT_A + 4) @(negedge clk);

        run_a(CH_ZERO, 1'b1, 8'h00, 8'h00);
        repeat (LAT_A + 4) @(negedge clk);
        run_a(CH_ONES, 1'b1, 8'hFF, 8'h00);
        repeat (LAT_A + 4) @(negedge clk);
        check("hold_response_word", 32'(ifa.response_word), 32'hFF);

        mode_a = 2'd1;
        run_a(CH_COLL, 1'b1, 8'hFE, 8'h01);
        repeat (LAT_A + 4) @(negedge clk);
        mode_a = 2'd0;

        // Extra start pulses mid-run, with a scrambled challenge on the bus, must be ignored
        run_a(CH_MIXED, 1'b1, 8'hA9, 8'h04);
        repeat (4) @(negedge clk);
        ifa.challenge = '0;
        ifa.start     = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (14) @(negedge clk);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (LAT_A) @(negedge clk);

        // Reset in the second pair's window discards the partial response
        run_a(CH_MIXED, 1'b0, 8'h00, 8'h00);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle_a("abort");
        repeat (LAT_A + 10) @(negedge clk);
        run_a(CH_ONES, 1'b1, 8'hFF, 8'h00);
        repeat (LAT_A + 4) @(negedge clk);

        // WINDOW=1 instance
        run_b(CH_ONES, 8'hFF, 8'h00);
        repeat (LAT_B + 4) @(negedge clk);
        run_b(CH_MIXED, 8'hA9, 8'h04);
        repeat (LAT_B + 4) @(negedge clk);
        mode_b = 2'd1;
        run_b(CH_COLL, 8'hFE, 8'h01);
        repeat (LAT_B + 4) @(negedge clk);

`ifdef PUF_MAJORITY_VOTE_EN
        // Pair 0 sees 1,0,1 across its three samples; all later samples are 0
        mode_a   = 2'd2;
        script_a = 1'b1;
        run_a(CH_ZERO, 1'b1, 8'h01, 8'h00);
        repeat (7) @(negedge clk);
        script_a = 1'b0;
        repeat (7) @(negedge clk);
        script_a = 1'b1;
        repeat (7) @(negedge clk);
        script_a = 1'b0;
        repeat (LAT_A) @(negedge clk);

        // Pair 0 sees 0,0,1
        run_a(CH_ZERO, 1'b1, 8'h00, 8'h00);
        repeat (14) @(negedge clk);
        script_a = 1'b1;
        repeat (7) @(negedge clk);
        script_a = 1'b0;
        repeat (LAT_A) @(negedge clk);
        mode_a = 2'd0;
`endif

        check("a_pending_done", 32'(qa.size()), 32'd0);
        check("b_pending_done", 32'(qb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
